// File: rtl/bus_target_pkg.sv
// Shared definitions for the bus target memory: FSM state encoding,
// word-index width and the size of the decoded address window.
package bus_target_pkg;

  localparam int IndexWidth = 9;
  localparam int WindowSize = 2048;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ_DATA,
    READ_END,
    ERROR
  } state_t;

endpackage

// File: rtl/bus_target_memory_if.sv
// Multiplexed address/data bus between an initiator (master) and the
// memory target (slave). Signals ending in IN are driven by the initiator
// side, signals ending in OUT by the target.
interface bus_target_memory_if;

  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic        errorIN;

  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  modport master (
    output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN, errorIN,
    input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

  modport slave (
    input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
           begin_transactionIN, end_transactionIN, data_validIN, busyIN, errorIN,
    output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
  );

endinterface

// File: rtl/bus_target_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Read data appears one cycle after the address is presented; a write and
// a read to the same address in one cycle returns the old contents.
module bus_target_ram
  import bus_target_pkg::*;
#(
  parameter int Depth     = 512,
  parameter int AddrWidth = IndexWidth
) (
  input  logic                 clk_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  input  logic                 we_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Byte-lane write plus unconditional registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_target_memory.sv
// Bus target exposing a 2 KB word memory on a multiplexed address/data bus.
// Supports burst reads and writes, range checking against the window end
// and initiator-driven aborts.
// Optional feature macro: BUS_TARGET_WAIT_STATE_EN -- when defined, the
// target inserts one busy cycle after every accepted write word.
module bus_target_memory
  import bus_target_pkg::*;
#(
  parameter logic [31:0] Base      = 32'h40000000,
  parameter int          NrOfWords = 512
) (
  input  logic              clock,
  input  logic              reset,
  bus_target_memory_if.slave bus
);

  localparam int OffsetBits = $clog2(WindowSize);
  localparam int LastIdx    = NrOfWords - 1;
  localparam logic [IndexWidth-1:0] IdxOne = IndexWidth'(1);

  state_t                state_q, state_d;
  logic [IndexWidth-1:0] index_q, index_d;
  logic [IndexWidth-1:0] remaining_q, remaining_d;
  logic [3:0]            be_q, be_d;

  logic                  hit;
  logic [IndexWidth-1:0] reqIndex;
  logic [IndexWidth:0]   rangeEnd;
  logic                  writeAccept;
  logic                  abortRead;
  logic                  waitStall;
  logic [IndexWidth-1:0] ramAddr;
  logic [31:0]           ramRdata;

  assign hit         = (bus.address_dataIN[31:OffsetBits] == Base[31:OffsetBits]);
  assign reqIndex    = bus.address_dataIN[OffsetBits-1:2];
  assign rangeEnd    = {1'b0, reqIndex} + {{(IndexWidth-7){1'b0}}, bus.burst_sizeIN};
  assign writeAccept = (state_q == WRITE) && bus.data_validIN && !waitStall
                       && (remaining_q != '0);
  assign abortRead   = bus.errorIN || bus.end_transactionIN;

`ifdef BUS_TARGET_WAIT_STATE_EN
  logic busy_q;

  // One stall cycle follows each accepted write word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= writeAccept;
    end
  end

  assign waitStall = busy_q;
`else
  assign waitStall = 1'b0;
`endif

  // State and burst bookkeeping registers; memory contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      remaining_q <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
      be_q        <= be_d;
    end
  end

  // Next-state logic. During reads the RAM address runs one word ahead of
  // the word on the bus, so holding the address re-reads the same word
  // while the initiator is busy.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    be_d        = be_q;
    ramAddr     = index_q;

    case (state_q)
      IDLE: begin
        if (bus.begin_transactionIN && hit) begin
          if (int'(rangeEnd) > LastIdx) begin
            state_d = ERROR;
          end else begin
            index_d     = reqIndex;
            remaining_d = {{(IndexWidth-8){1'b0}}, bus.burst_sizeIN} + IdxOne;
            be_d        = bus.byte_enableIN;
            state_d     = bus.read_n_writeIN ? READ_WAIT : WRITE;
          end
        end
      end

      WRITE: begin
        if (writeAccept) begin
          index_d     = index_q + IdxOne;
          remaining_d = remaining_q - IdxOne;
        end
        if (bus.end_transactionIN) begin
          state_d = IDLE;
        end
      end

      READ_WAIT: begin
        state_d = abortRead ? IDLE : READ_DATA;
      end

      READ_DATA: begin
        if (abortRead) begin
          state_d = IDLE;
        end else if (!bus.busyIN) begin
          if (remaining_q == IdxOne) begin
            state_d = READ_END;
          end else begin
            index_d     = index_q + IdxOne;
            remaining_d = remaining_q - IdxOne;
            ramAddr     = index_q + IdxOne;
          end
        end
      end

      READ_END: state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  bus_target_ram #(
    .Depth     (NrOfWords),
    .AddrWidth (IndexWidth)
  ) uRam (
    .clk_i   (clock),
    .addr_i  (ramAddr),
    .wdata_i (bus.address_dataIN),
    .be_i    (be_q),
    .we_i    (writeAccept && reset),
    .rdata_o (ramRdata)
  );

  assign bus.data_validOUT      = (state_q == READ_DATA);
  assign bus.address_dataOUT    = (state_q == READ_DATA) ? ramRdata : '0;
  assign bus.end_transactionOUT = (state_q == READ_END);
  assign bus.errorOUT           = (state_q == ERROR);
  assign bus.busyOUT            = waitStall;

endmodule

// File: tb/tb_bus_target_memory.sv
// Directed testbench for bus_target_memory. Honours
// BUS_TARGET_WAIT_STATE_EN so the same bench covers both builds.
module tb_bus_target_memory;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  bus_target_memory_if busIf();

  bus_target_memory #(
    .Base      (32'h40000000),
    .NrOfWords (512)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] wrWords  [4];
  logic [31:0] expWords [4];

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Verify that every target output is idle.
  task automatic checkQuiet(input string tag);
    checkOutput({tag, " data"},  busIf.address_dataOUT, 32'h0);
    checkOutput({tag, " valid"}, {31'b0, busIf.data_validOUT}, 32'h0);
    checkOutput({tag, " end"},   {31'b0, busIf.end_transactionOUT}, 32'h0);
    checkOutput({tag, " busy"},  {31'b0, busIf.busyOUT}, 32'h0);
    checkOutput({tag, " error"}, {31'b0, busIf.errorOUT}, 32'h0);
  endtask

  // Drive the address phase for one cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] be,
                               input logic [7:0] burst, input logic rnw);
    busIf.address_dataIN      = addr;
    busIf.byte_enableIN       = be;
    busIf.burst_sizeIN        = burst;
    busIf.read_n_writeIN      = rnw;
    busIf.begin_transactionIN = 1'b1;
    tick();
    busIf.begin_transactionIN = 1'b0;
    busIf.address_dataIN      = 32'h0;
  endtask

  // Write n words from wrWords, ending the transaction with the last word.
  task automatic writeBurst(input logic [31:0] addr, input logic [3:0] be, input int n);
    applyStimulus(addr, be, 8'(n - 1), 1'b0);
    for (int i = 0; i < n; i++) begin
      busIf.address_dataIN    = wrWords[i];
      busIf.data_validIN      = 1'b1;
      busIf.end_transactionIN = (i == n - 1);
      tick();
`ifdef BUS_TARGET_WAIT_STATE_EN
      checkOutput("wr busy pulse", {31'b0, busIf.busyOUT}, 32'h1);
      busIf.data_validIN      = 1'b0;
      busIf.end_transactionIN = 1'b0;
      tick();
      checkOutput("wr busy clear", {31'b0, busIf.busyOUT}, 32'h0);
`else
      checkOutput("wr busy low", {31'b0, busIf.busyOUT}, 32'h0);
`endif
    end
    busIf.data_validIN      = 1'b0;
    busIf.end_transactionIN = 1'b0;
    busIf.address_dataIN    = 32'h0;
    tick();
  endtask

  // Read n words and compare with expWords; busyIN is held for stallCycles
  // cycles while word stallWord is on the bus.
  task automatic readBurst(input logic [31:0] addr, input int n,
                           input int stallWord, input int stallCycles);
    int validCycles;
    int expCycles;
    validCycles = 0;
    expCycles   = n + ((stallWord < n) ? stallCycles : 0);
    applyStimulus(addr, 4'hF, 8'(n - 1), 1'b1);
    checkOutput("rd wait valid", {31'b0, busIf.data_validOUT}, 32'h0);
    tick();
    for (int i = 0; i < n; i++) begin
      checkOutput("rd valid", {31'b0, busIf.data_validOUT}, 32'h1);
      checkOutput("rd data", busIf.address_dataOUT, expWords[i]);
      if (busIf.data_validOUT) validCycles++;
      if (i == stallWord) begin
        for (int s = 0; s < stallCycles; s++) begin
          busIf.busyIN = 1'b1;
          tick();
          checkOutput("rd hold valid", {31'b0, busIf.data_validOUT}, 32'h1);
          checkOutput("rd hold data", busIf.address_dataOUT, expWords[i]);
          if (busIf.data_validOUT) validCycles++;
        end
        busIf.busyIN = 1'b0;
      end
      tick();
    end
    checkOutput("rd end pulse", {31'b0, busIf.end_transactionOUT}, 32'h1);
    checkOutput("rd end valid", {31'b0, busIf.data_validOUT}, 32'h0);
    checkOutput("rd valid cycles", 32'(validCycles), 32'(expCycles));
    tick();
    checkOutput("rd end clear", {31'b0, busIf.end_transactionOUT}, 32'h0);
  endtask

  // Guard against a hung run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    busIf.address_dataIN      = 32'h0;
    busIf.byte_enableIN       = 4'h0;
    busIf.burst_sizeIN        = 8'h0;
    busIf.read_n_writeIN      = 1'b0;
    busIf.begin_transactionIN = 1'b0;
    busIf.end_transactionIN   = 1'b0;
    busIf.data_validIN        = 1'b0;
    busIf.busyIN              = 1'b0;
    busIf.errorIN             = 1'b0;

    reset = 1'b0;
    tick();
    tick();
    checkQuiet("reset");
    reset = 1'b1;
    tick();

    // Full-word write then single read.
    wrWords[0] = 32'hDEADBEEF;
    writeBurst(32'h40000010, 4'hF, 1);
    expWords[0] = 32'hDEADBEEF;
    readBurst(32'h40000010, 1, 99, 0);

    // Partial byte-lane write merges with the old word.
    wrWords[0] = 32'h12345678;
    writeBurst(32'h40000010, 4'b0011, 1);
    expWords[0] = 32'hDEAD5678;
    readBurst(32'h40000010, 1, 99, 0);

    // Four-word burst write, then burst read with two stall cycles on word 1.
    wrWords[0] = 32'h11111111;
    wrWords[1] = 32'h22222222;
    wrWords[2] = 32'h33333333;
    wrWords[3] = 32'h44444444;
    writeBurst(32'h40000000, 4'hF, 4);
    expWords[0] = 32'h11111111;
    expWords[1] = 32'h22222222;
    expWords[2] = 32'h33333333;
    expWords[3] = 32'h44444444;
    readBurst(32'h40000000, 4, 1, 2);

    // Range error at the top of the window leaves memory untouched.
    wrWords[0] = 32'hCAFEF00D;
    writeBurst(32'h400007FC, 4'hF, 1);
    applyStimulus(32'h400007FC, 4'hF, 8'd1, 1'b0);
    checkOutput("range error", {31'b0, busIf.errorOUT}, 32'h1);
    busIf.address_dataIN    = 32'h0BADBAD0;
    busIf.data_validIN      = 1'b1;
    tick();
    checkOutput("range error clear", {31'b0, busIf.errorOUT}, 32'h0);
    busIf.data_validIN      = 1'b0;
    busIf.end_transactionIN = 1'b1;
    tick();
    busIf.end_transactionIN = 1'b0;
    busIf.address_dataIN    = 32'h0;
    expWords[0] = 32'hCAFEF00D;
    readBurst(32'h400007FC, 1, 99, 0);

    // Miss is ignored; a hit in the very next cycle is served.
    applyStimulus(32'h50000000, 4'hF, 8'd0, 1'b1);
    checkQuiet("miss");
    expWords[0] = 32'h11111111;
    readBurst(32'h40000000, 1, 99, 0);

    // Initiator aborts a read burst after the first word.
    applyStimulus(32'h40000000, 4'hF, 8'd3, 1'b1);
    tick();
    checkOutput("abort first data", busIf.address_dataOUT, 32'h11111111);
    busIf.end_transactionIN = 1'b1;
    tick();
    busIf.end_transactionIN = 1'b0;
    checkOutput("abort valid", {31'b0, busIf.data_validOUT}, 32'h0);
    checkOutput("abort data", busIf.address_dataOUT, 32'h0);
    tick();
    checkOutput("abort stays idle", {31'b0, busIf.data_validOUT}, 32'h0);

    // Reset in the middle of a write burst blocks the pending word.
    wrWords[0] = 32'hA0A0A0A0;
    wrWords[1] = 32'hB0B0B0B0;
    writeBurst(32'h40000100, 4'hF, 2);
    applyStimulus(32'h40000100, 4'hF, 8'd1, 1'b0);
    busIf.address_dataIN = 32'h12121212;
    busIf.data_validIN   = 1'b1;
    tick();
    busIf.address_dataIN = 32'h34343434;
    reset = 1'b0;
    tick();
    checkQuiet("mid reset");
    reset              = 1'b1;
    busIf.data_validIN = 1'b0;
    busIf.address_dataIN = 32'h0;
    tick();
    expWords[0] = 32'h12121212;
    expWords[1] = 32'hB0B0B0B0;
    readBurst(32'h40000100, 2, 99, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
